// File: rtl/pov_pkg.sv
// Shared definitions for the POV frame buffer.
// Holds the default geometry of the double-buffered frame memory and the
// typed bank index used to tell the displayed bank from the loading bank.
package pov_pkg;

    localparam int POV_DWIDTH = 16;   // one LED column word
    localparam int POV_AWIDTH = 8;    // address width per bank
    localparam int POV_WORDS  = 256;  // words per bank
    localparam int POV_CWIDTH = 8;    // swap counter width

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    // The bank that is not the one given: front <-> back.
    function automatic bank_e other_bank(input bank_e b);
        bank_e r;
        if (b == BANK_0) begin
            r = BANK_1;
        end else begin
            r = BANK_0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pov_bank_ram.sv
// Single bank of the POV frame memory: simple dual-port RAM, one write port
// and one read port with a registered read (latency 1).
// Ports:
//   clk   - system clock
//   we    - write enable; waddr/wdata written on the rising edge
//   waddr - write address (caller guarantees < WORDS when we=1)
//   wdata - write data
//   re    - read enable; rdata loads mem[raddr] on the rising edge
//   raddr - read address (caller guarantees < WORDS when re=1)
//   rdata - registered read data, holds its value while re=0
// Contents and read register are deliberately not reset.
module pov_bank_ram
    import pov_pkg::*;
#(
    parameter int DWIDTH = POV_DWIDTH,
    parameter int AWIDTH = POV_AWIDTH,
    parameter int WORDS  = POV_WORDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [WORDS];
    logic [DWIDTH-1:0] rdata_q;

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port; holds the last word when not enabled.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pov_frame_buffer.sv
// Double-buffered (ping-pong) frame memory for the POV LED path.
// The loader writes the back bank while the LED scanner reads the front bank;
// the banks swap only when a fully loaded frame is pending and the scanner
// signals the end of a revolution, so a half-loaded image is never shown.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   wr_en/addr/data  - loader write into the back bank
//   wr_last          - with wr_en: this word completes the frame load
//   wr_ready         - back bank accepts writes (no frame waiting to swap)
//   rd_en/rd_addr    - scanner read of the front bank
//   rd_data/rd_valid - read result, one cycle after rd_en
//   rd_frame_end     - end of revolution, the only legal swap point
//   front_bank       - index of the displayed bank
//   swap_pending     - a loaded frame is waiting for the next frame end
//   swap_count       - completed swaps, wraps
//   wr_drop          - sticky: a write arrived while wr_ready was low
module pov_frame_buffer
    import pov_pkg::*;
#(
    parameter int DWIDTH = POV_DWIDTH,
    parameter int AWIDTH = POV_AWIDTH,
    parameter int WORDS  = POV_WORDS,
    parameter int CWIDTH = POV_CWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_frame_end,
    output logic              front_bank,
    output logic              swap_pending,
    output logic [CWIDTH-1:0] swap_count,
    output logic              wr_drop
);

    // Control state.
    bank_e             front_bank_q,   front_bank_d;
    logic              swap_pending_q, swap_pending_d;
    logic [CWIDTH-1:0] swap_count_q,   swap_count_d;
    logic              wr_drop_q,      wr_drop_d;
    logic              rd_valid_q,     rd_valid_d;
    // Read-side bookkeeping: which bank produced the last read, and whether
    // the last read was out of range (forces rd_data to zero).
    bank_e             rd_sel_q,       rd_sel_d;
    logic              rd_zero_q,      rd_zero_d;

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_accept;
    logic              mem_we;
    logic              mem_re;
    logic              swap_fire;
    logic              we0, we1, re0, re1;
    logic [DWIDTH-1:0] rdata0, rdata1;

    // Zero-extend to 32 bits so WORDS == 2**AWIDTH compares correctly.
    assign wr_in_range = ({{(32-AWIDTH){1'b0}}, wr_addr} < 32'(WORDS));
    assign rd_in_range = ({{(32-AWIDTH){1'b0}}, rd_addr} < 32'(WORDS));

    // Next-state logic for swap handshake, flags and read bookkeeping.
    always_comb begin
        front_bank_d   = front_bank_q;
        swap_pending_d = swap_pending_q;
        swap_count_d   = swap_count_q;
        wr_drop_d      = wr_drop_q;
        rd_valid_d     = rd_en;
        rd_sel_d       = rd_sel_q;
        rd_zero_d      = rd_zero_q;

        wr_accept = wr_en & ~swap_pending_q;
        // Swap uses the registered pending flag, so a wr_last landing on the
        // same edge as rd_frame_end waits for the next frame end.
        swap_fire = rd_frame_end & swap_pending_q;

        if (swap_fire) begin
            front_bank_d   = other_bank(front_bank_q);
            swap_pending_d = 1'b0;
            swap_count_d   = swap_count_q + CWIDTH'(1'b1);
        end else if (wr_accept && wr_last) begin
            swap_pending_d = 1'b1;
        end else begin
            swap_pending_d = swap_pending_q;
        end

        if (wr_en && swap_pending_q) begin
            wr_drop_d = 1'b1;
        end else begin
            wr_drop_d = wr_drop_q;
        end

        if (rd_en) begin
            rd_sel_d  = front_bank_q;
            rd_zero_d = ~rd_in_range;
        end else begin
            rd_sel_d  = rd_sel_q;
            rd_zero_d = rd_zero_q;
        end
    end

    // Reset has priority: no memory traffic while rst is high.
    assign mem_we = wr_accept & wr_in_range & ~rst;
    assign mem_re = rd_en & rd_in_range & ~rst;

    // Writes go to the back bank, reads to the front bank.
    assign we0 = mem_we & (front_bank_q == BANK_1);
    assign we1 = mem_we & (front_bank_q == BANK_0);
    assign re0 = mem_re & (front_bank_q == BANK_0);
    assign re1 = mem_re & (front_bank_q == BANK_1);

    // Control and read-bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_bank_q   <= BANK_0;
            swap_pending_q <= 1'b0;
            swap_count_q   <= {CWIDTH{1'b0}};
            wr_drop_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_sel_q       <= BANK_0;
            rd_zero_q      <= 1'b1;
        end else begin
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
            swap_count_q   <= swap_count_d;
            wr_drop_q      <= wr_drop_d;
            rd_valid_q     <= rd_valid_d;
            rd_sel_q       <= rd_sel_d;
            rd_zero_q      <= rd_zero_d;
        end
    end

    pov_bank_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (re0),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    pov_bank_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .WORDS  (WORDS)
    ) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (re1),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // Output select is driven only by registers, so rd_data holds while
    // rd_en is low and reads zero after reset or an out-of-range read.
    assign rd_data      = rd_zero_q ? {DWIDTH{1'b0}}
                                    : ((rd_sel_q == BANK_1) ? rdata1 : rdata0);
    assign rd_valid     = rd_valid_q;
    assign wr_ready     = ~swap_pending_q;
    assign front_bank   = front_bank_q;
    assign swap_pending = swap_pending_q;
    assign swap_count   = swap_count_q;
    assign wr_drop      = wr_drop_q;

endmodule

// File: tb/tb_pov_frame_buffer.sv
// Self-checking bench for pov_frame_buffer. A behavioural model of both banks
// and the swap handshake predicts every read; expected read words are queued
// when the read is issued and popped when rd_valid is due. A second instance
// with WORDS=200 covers out-of-range addresses.
module tb_pov_frame_buffer;

    localparam int WORDS_A = 256;

    logic        clk;
    logic        rst;
    logic        wr_en, wr_last, rd_en, rd_frame_end;
    logic [7:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_ready, rd_valid, front_bank, swap_pending, wr_drop;
    logic [15:0] rd_data;
    logic [7:0]  swap_count;

    logic        b_wr_en, b_wr_last, b_rd_en, b_rd_frame_end;
    logic [7:0]  b_wr_addr, b_rd_addr;
    logic [15:0] b_wr_data;
    logic        b_wr_ready, b_rd_valid, b_front_bank, b_swap_pending, b_wr_drop;
    logic [15:0] b_rd_data;
    logic [7:0]  b_swap_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [15:0] m_mem [2][256];
    logic        m_front, m_pending, m_drop;
    logic [7:0]  m_count;
    logic [15:0] sb_q [$];
    logic [15:0] b_sb_q [$];

    pov_frame_buffer u_dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_frame_end(rd_frame_end), .front_bank(front_bank),
        .swap_pending(swap_pending), .swap_count(swap_count), .wr_drop(wr_drop)
    );

    pov_frame_buffer #(.WORDS(200)) u_dut200 (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_last(b_wr_last),
        .wr_ready(b_wr_ready),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .rd_frame_end(b_rd_frame_end), .front_bank(b_front_bank),
        .swap_pending(b_swap_pending), .swap_count(b_swap_count), .wr_drop(b_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus on the main instance; updates the model from the
    // pre-edge state and queues the expected read word.
    task automatic drive(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                         input logic wl, input logic re, input logic [7:0] ra,
                         input logic fe);
        logic old_p;
        old_p = m_pending;
        if (re) sb_q.push_back((int'(ra) >= WORDS_A) ? 16'h0000 : m_mem[m_front][ra]);
        if (we) begin
            if (old_p) begin
                m_drop = 1'b1;
            end else begin
                if (int'(wa) < WORDS_A) m_mem[~m_front][wa] = wd;
                if (wl) m_pending = 1'b1;
            end
        end
        if (fe && old_p) begin
            m_front   = ~m_front;
            m_pending = 1'b0;
            m_count   = m_count + 8'd1;
        end
        wr_en = we; wr_addr = wa; wr_data = wd; wr_last = wl;
        rd_en = re; rd_addr = ra; rd_frame_end = fe;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = 16'hDEAD; wr_last = 1'b1;
        rd_en = 1'b1; rd_addr = 8'd3; rd_frame_end = 1'b1;
        b_wr_en = 1'b1; b_wr_addr = 8'd3; b_wr_data = 16'hDEAD; b_wr_last = 1'b1;
        b_rd_en = 1'b1; b_rd_addr = 8'd3; b_rd_frame_end = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (front_bank !== 1'b0) begin n_fail++; $display("FAIL reset_front got=%b exp=0", front_bank); end
        n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", swap_pending); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        n_checks++; if (swap_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", swap_count); end
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", wr_drop); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
        rst = 1'b0;
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_frame_end = 1'b0;
        b_wr_en = 1'b0; b_wr_last = 1'b0; b_rd_en = 1'b0; b_rd_frame_end = 1'b0;
        m_front = 1'b0; m_pending = 1'b0; m_drop = 1'b0; m_count = 8'd0;
        sb_q.delete(); b_sb_q.delete();
    endtask

    task automatic test_load_swap();
        logic [15:0] exp;
        for (int i = 0; i < 256; i++)
            drive(1'b1, 8'(i), 16'h1000 + 16'(i), (i == 255), 1'b0, 8'd0, 1'b0);
        n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL load_pending got=%b exp=1", swap_pending); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready got=%b exp=0", wr_ready); end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        n_checks++; if (front_bank !== m_front) begin n_fail++; $display("FAIL swap_front got=%b exp=%b", front_bank, m_front); end
        n_checks++; if (swap_count !== 8'd1) begin n_fail++; $display("FAIL swap_count got=%0d exp=1", swap_count); end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'h10, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL read_0x10 got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || exp !== 16'h1010) begin
                n_fail++; $display("FAIL read_0x10 got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
            end
        end
        // Load bank 0 as well, so every word of both banks is known.
        for (int i = 0; i < 256; i++)
            drive(1'b1, 8'(i), 16'h2000 + 16'(i), (i == 255), 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'h33, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL read_bank0 got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || front_bank !== 1'b0) begin
                n_fail++; $display("FAIL read_bank0 got=%b/%h/front%b exp=1/%h/front0", rd_valid, rd_data, front_bank, exp);
            end
        end
    endtask

    task automatic test_isolation();
        logic [15:0] exp;
        drive(1'b1, 8'd5, 16'hBEEF, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'd5, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL iso_front got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || rd_data === 16'hBEEF) begin
                n_fail++; $display("FAIL iso_front got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
            end
        end
        drive(1'b1, 8'd6, 16'h6666, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'd5, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL iso_swapped got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || exp !== 16'hBEEF) begin
                n_fail++; $display("FAIL iso_swapped got=%b/%h exp=1/beef", rd_valid, rd_data);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        drive(1'b1, 8'd0, 16'h5555, 1'b1, 1'b0, 8'd0, 1'b0);
        n_checks++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL ovf_no_drop got=%b exp=0", wr_drop); end
        drive(1'b1, 8'd7, 16'hAAAA, 1'b0, 1'b0, 8'd0, 1'b0);
        n_checks++; if (wr_drop !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_drop got=%b/%b exp=1/0", wr_drop, wr_ready); end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'd7, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL ovf_unchanged got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || rd_data === 16'hAAAA) begin
                n_fail++; $display("FAIL ovf_unchanged got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
            end
        end
        n_checks++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", wr_drop); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp;
        logic        f0;
        f0 = m_front;
        drive(1'b1, 8'd9, 16'h9999, 1'b1, 1'b0, 8'd0, 1'b1);
        n_checks++; if (swap_pending !== 1'b1 || front_bank !== f0) begin n_fail++; $display("FAIL simul_no_swap got=%b/%b exp=1/%b", swap_pending, front_bank, f0); end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'd9, 1'b1);
        n_checks++; if (front_bank !== ~f0 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL simul_swap got=%b/%b exp=%b/0", front_bank, swap_pending, ~f0); end
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL read_on_swap got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || rd_data === 16'h9999) begin
                n_fail++; $display("FAIL read_on_swap got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
            end
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 8'd9, 1'b0);
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL read_new got=empty_queue exp=entry"); end
        else begin
            exp = sb_q.pop_front();
            if (rd_valid !== 1'b1 || rd_data !== exp || exp !== 16'h9999) begin
                n_fail++; $display("FAIL read_new got=%b/%h exp=1/9999", rd_valid, rd_data);
            end
        end
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h9999) begin n_fail++; $display("FAIL rd_hold got=%b/%h exp=0/9999", rd_valid, rd_data); end
        n_checks++; if (front_bank !== m_front) begin n_fail++; $display("FAIL idle_frame_end got=%b exp=%b", front_bank, m_front); end
    endtask

    task automatic test_boundary();
        logic [15:0] exp;
        b_wr_en = 1'b1; b_wr_addr = 8'd210; b_wr_data = 16'h1234; b_wr_last = 1'b0;
        @(posedge clk); #1;
        b_wr_addr = 8'd10; b_wr_data = 16'h0A0A; b_wr_last = 1'b1;
        @(posedge clk); #1;
        b_wr_en = 1'b0; b_wr_last = 1'b0;
        n_checks++; if (b_wr_drop !== 1'b0 || b_swap_pending !== 1'b1) begin n_fail++; $display("FAIL oor_write_flags got=%b/%b exp=0/1", b_wr_drop, b_swap_pending); end
        b_rd_frame_end = 1'b1;
        @(posedge clk); #1;
        b_rd_frame_end = 1'b0;
        n_checks++; if (b_front_bank !== 1'b1) begin n_fail++; $display("FAIL b_swap got=%b exp=1", b_front_bank); end
        b_rd_en = 1'b1; b_rd_addr = 8'd10; b_sb_q.push_back(16'h0A0A);
        @(posedge clk); #1;
        b_rd_addr = 8'd210; b_sb_q.push_back(16'h0000);
        n_checks++;
        if (b_sb_q.size() == 0) begin n_fail++; $display("FAIL b_read_10 got=empty_queue exp=entry"); end
        else begin
            exp = b_sb_q.pop_front();
            if (b_rd_valid !== 1'b1 || b_rd_data !== exp) begin n_fail++; $display("FAIL b_read_10 got=%b/%h exp=1/%h", b_rd_valid, b_rd_data, exp); end
        end
        @(posedge clk); #1;
        b_rd_en = 1'b0;
        n_checks++;
        if (b_sb_q.size() == 0) begin n_fail++; $display("FAIL b_read_210 got=empty_queue exp=entry"); end
        else begin
            exp = b_sb_q.pop_front();
            if (b_rd_valid !== 1'b1 || b_rd_data !== exp) begin n_fail++; $display("FAIL b_read_210 got=%b/%h exp=1/%h", b_rd_valid, b_rd_data, exp); end
        end
    endtask

    task automatic test_wrap();
        while (m_count != 8'hFF) begin
            drive(1'b1, 8'd1, {8'h00, m_count}, 1'b1, 1'b0, 8'd0, 1'b0);
            drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        end
        n_checks++; if (swap_count !== 8'hFF) begin n_fail++; $display("FAIL count_255 got=%0d exp=255", swap_count); end
        drive(1'b1, 8'd1, 16'h00FF, 1'b1, 1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 8'd0, 1'b1);
        n_checks++; if (swap_count !== 8'd0 || m_count !== 8'd0) begin n_fail++; $display("FAIL count_wrap got=%0d exp=0", swap_count); end
        n_checks++; if (front_bank !== m_front) begin n_fail++; $display("FAIL wrap_front got=%b exp=%b", front_bank, m_front); end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = 8'd0; wr_data = 16'h0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = 8'd0; rd_frame_end = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = 8'd0; b_wr_data = 16'h0; b_wr_last = 1'b0;
        b_rd_en = 1'b0; b_rd_addr = 8'd0; b_rd_frame_end = 1'b0;
        test_reset();
        test_load_swap();
        test_isolation();
        test_overflow();
        test_simultaneous();
        test_boundary();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pov_frame_buffer.md
Name: pov_frame_buffer

Overview:
- Double-buffered (ping-pong) line/frame memory for the POV LED path. Two banks of WORDS x DWIDTH.
- The ROM/loader side writes the next image into the back bank while the LED scan side reads the front bank.
- Banks swap only at a display frame boundary (end of revolution), so a partially loaded image is never shown.
- Successor to the single-bank 256x16 RAM: parametrised geometry, separate read/write ports, bank swap handshake, registered read valid, overflow flag.

Parameters:
- DWIDTH, 16, data word width (one LED column word).
- AWIDTH, 8, address width per bank.
- WORDS, 256, words per bank; must satisfy WORDS <= 2**AWIDTH.
- CWIDTH, 8, width of swap_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe into back bank.
- wr_addr  in  AWIDTH  write address.
- wr_data  in  DWIDTH  write data (from ROM/loader).
- wr_last  in  1  qualifies wr_en: this word completes the frame load.
- wr_ready  out  1  high when back bank accepts writes (= ~swap_pending).
- rd_en  in  1  read strobe from LED scanner.
- rd_addr  in  AWIDTH  read address in front bank.
- rd_data  out  DWIDTH  registered read data.
- rd_valid  out  1  rd_data valid this cycle.
- rd_frame_end  in  1  scanner pulse: end of revolution, legal swap point.
- front_bank  out  1  index of bank currently displayed.
- swap_pending  out  1  loaded frame waiting for swap.
- swap_count  out  CWIDTH  number of completed swaps, wraps modulo 2**CWIDTH.
- wr_drop  out  1  sticky: a write was attempted while wr_ready=0.

Behaviour:
- Reset values (cycle after rst=1): front_bank=0, swap_pending=0, swap_count=0, wr_drop=0, rd_data=0, rd_valid=0. Memory contents are not reset; rst has priority over all other inputs.
- Write:
  - wr_en & wr_ready writes wr_data to bank ~front_bank at wr_addr on the same edge.
  - wr_en while wr_ready=0: no memory write, wr_drop<=1 (sticky until rst).
  - wr_addr >= WORDS: write ignored, no flag.
- Frame load complete:
  - wr_en & wr_last & wr_ready: the word is written and swap_pending<=1.
  - wr_last without wr_en is ignored.
- Swap:
  - On an edge with rd_frame_end=1 and swap_pending=1 (registered value): front_bank<=~front_bank, swap_pending<=0, swap_count<=swap_count+1.
  - rd_frame_end with swap_pending=0: no effect, the old image is redisplayed.
  - wr_last and rd_frame_end in the same cycle: the pending flag is set, no swap that cycle; the swap occurs at the next rd_frame_end.
- Read:
  - Latency 1. rd_en at edge N gives rd_data/rd_valid at N+1, using front_bank as registered before edge N.
  - A read issued in the same cycle as a swap returns old-front-bank data.
  - rd_en=0: rd_valid<=0 and rd_data holds its last value.
  - rd_addr >= WORDS: rd_valid<=1, rd_data<=0.
- After a swap, the new back bank holds the previously displayed frame (stale). The writer overwrites it; there is no clear.
- Read and write of the same address are always in different banks, so there are no collisions.
- Reset mid-load: swap_pending cleared, front_bank=0. The partially written back bank (bank 1) is then the back bank, and the loader restarts.

Decomposition:
- Shared package (pov_pkg): default DWIDTH/AWIDTH/WORDS constants, and a bank-index type if the team uses typed indices.
- One natural sub-module: pov_bank_ram, a single-bank simple dual-port RAM with a registered read, instantiated twice. Its read port is selected by front_bank and its write port by ~front_bank.
- Swap/pending control and flags stay in the top module.

Test Plan:
- Reset: assert rst with wr_en/rd_en active -> next cycle front_bank=0, swap_pending=0, rd_valid=0, rd_data=0, swap_count=0, wr_drop=0.
- Load and swap:
  - Write 0x1000+i to addr 0..255, wr_last on addr 255 -> swap_pending=1, wr_ready=0.
  - Then pulse rd_frame_end -> front_bank=1, swap_count=1.
  - Then rd_en addr 0x10 -> rd_data=0x1010 one cycle later with rd_valid=1.
- Isolation:
  - Before any swap, write 0xBEEF to addr 5 (goes to bank 1).
  - rd_en addr 5 -> returns bank-0 data, not 0xBEEF.
  - After wr_last plus rd_frame_end, the same read returns 0xBEEF.
- Overflow: with swap_pending=1, wr_en addr 7 data 0xAAAA -> wr_drop=1 and the back bank addr 7 is unchanged (checked after the next load/swap cycle).
- Simultaneous events:
  - wr_last and rd_frame_end in the same cycle -> no swap, swap_pending=1; next rd_frame_end -> swap.
  - A read issued on the swap cycle returns old-bank data.
- Boundary: with WORDS=200, a write to addr 210 is ignored; a read of addr 210 gives rd_valid=1 and rd_data=0. After 256 swaps, swap_count wraps to 0.
